// File: rtl/mul_sp.sv
// -----------------------------------------------------------------------------
// mul_sp : sequential IEEE-754 single-precision multiplier
//
// Builds the 48-bit mantissa product by iterative shift-add. Each MUL cycle
// retires BITS_PER_CYCLE multiplier bits, most significant slice first, so the
// product takes K = 24/BITS_PER_CYCLE cycles. Subnormal operands are treated
// as zero. Results are never subnormal; underflow flushes to signed zero.
//
// Build option: ROUND_NEAREST_EN
//   defined   -> round-to-nearest-even
//   undefined -> truncate (round toward zero); guard/sticky are not built
//   Latency is the same in both builds.
//
// Parameters:
//   BITS_PER_CYCLE : multiplier bits per MUL cycle (1,2,3,4,6,8,12,24)
//
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-high reset
//   start  : operation request, sampled only while idle
//   i_a    : operand A, captured on the accepted start edge
//   i_b    : operand B, captured on the accepted start edge
//   o_z    : result, holds until the next completion
//   o_busy : high whenever an operation is in flight
//   o_done : one-cycle pulse coincident with o_z update
// -----------------------------------------------------------------------------
module mul_sp #(
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_z,
  output logic        o_busy,
  output logic        o_done
);

  localparam int K = 24 / BITS_PER_CYCLE;
  localparam logic [4:0] LAST_CNT = 5'(K - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UNPACK = 2'd1,
    MUL    = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t state_r, state_nx_s;

  logic [31:0]       a_r, b_r;
  logic [23:0]       mb_r;
  logic [47:0]       acc_r;
  logic [4:0]        count_r;
  logic signed [9:0] exp_sum_r;
  logic              sign_r;
  logic              special_r;
  logic [31:0]       preset_r;

  // operand classification
  logic [7:0]        a_exp_s, b_exp_s;
  logic              a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s;
  logic              special_s, z_sign_s;
  logic signed [9:0] exp_sum_s;
  logic [31:0]       preset_s;

  assign a_exp_s   = a_r[30:23];
  assign b_exp_s   = b_r[30:23];
  assign a_zero_s  = (a_exp_s == 8'd0);
  assign b_zero_s  = (b_exp_s == 8'd0);
  assign a_inf_s   = (a_exp_s == 8'hFF) && (a_r[22:0] == 23'd0);
  assign b_inf_s   = (b_exp_s == 8'hFF) && (b_r[22:0] == 23'd0);
  assign a_nan_s   = (a_exp_s == 8'hFF) && (a_r[22:0] != 23'd0);
  assign b_nan_s   = (b_exp_s == 8'hFF) && (b_r[22:0] != 23'd0);
  assign special_s = a_zero_s || b_zero_s || (a_exp_s == 8'hFF) || (b_exp_s == 8'hFF);
  assign z_sign_s  = a_r[31] ^ b_r[31];
  assign exp_sum_s = $signed({2'b00, a_exp_s}) + $signed({2'b00, b_exp_s}) - 10'sd127;

  // special-operand result, NaN cases take priority over inf, inf over zero
  always_comb begin
    preset_s = 32'd0;
    if (a_nan_s || b_nan_s || (a_inf_s && b_zero_s) || (b_inf_s && a_zero_s)) begin
      preset_s = 32'h7FC0_0000;
    end else if (a_inf_s || b_inf_s) begin
      preset_s = {z_sign_s, 8'hFF, 23'd0};
    end else if (a_zero_s || b_zero_s) begin
      preset_s = {z_sign_s, 31'd0};
    end else begin
      preset_s = 32'd0;
    end
  end

  // shift-add step: acc = acc*2^B + {1,ma} * next multiplier slice
  logic [BITS_PER_CYCLE-1:0]  slice_s;
  logic [23+BITS_PER_CYCLE:0] pp_s;
  logic [47:0]                acc_nx_s;

  assign slice_s  = mb_r[23 -: BITS_PER_CYCLE];
  assign pp_s     = {{BITS_PER_CYCLE{1'b0}}, 1'b1, a_r[22:0]} * {24'd0, slice_s};
  assign acc_nx_s = {acc_r[47-BITS_PER_CYCLE:0], {BITS_PER_CYCLE{1'b0}}} + 48'(pp_s);

  // normalize, round and range-check the finished product
  logic [22:0]       mant_s, mant_f_s;
  logic [23:0]       mant_rnd_s;
  logic signed [9:0] exp_n_s, exp_f_s;
  logic              inc_s;
  logic [31:0]       result_s;

`ifdef ROUND_NEAREST_EN
  logic guard_s, sticky_s;
`else
  logic unused_s;
  assign unused_s = ^acc_r[22:0];
`endif

  // product normalization: bit 47 set means the product is in [2,4)
  always_comb begin
    mant_s  = 23'd0;
    exp_n_s = exp_sum_r;
`ifdef ROUND_NEAREST_EN
    guard_s  = 1'b0;
    sticky_s = 1'b0;
`endif
    if (acc_r[47]) begin
      mant_s  = acc_r[46:24];
      exp_n_s = exp_sum_r + 10'sd1;
`ifdef ROUND_NEAREST_EN
      guard_s  = acc_r[23];
      sticky_s = |acc_r[22:0];
`endif
    end else begin
      mant_s  = acc_r[45:23];
      exp_n_s = exp_sum_r;
`ifdef ROUND_NEAREST_EN
      guard_s  = acc_r[22];
      sticky_s = |acc_r[21:0];
`endif
    end
  end

`ifdef ROUND_NEAREST_EN
  assign inc_s = guard_s & (sticky_s | mant_s[0]);
`else
  assign inc_s = 1'b0;
`endif

  assign mant_rnd_s = {1'b0, mant_s} + {23'd0, inc_s};

  // rounding carry-out renormalizes to 1.0 with exponent bump, then range check
  always_comb begin
    mant_f_s = 23'd0;
    exp_f_s  = exp_n_s;
    result_s = 32'd0;
    if (mant_rnd_s[23]) begin
      mant_f_s = 23'd0;
      exp_f_s  = exp_n_s + 10'sd1;
    end else begin
      mant_f_s = mant_rnd_s[22:0];
      exp_f_s  = exp_n_s;
    end
    if (exp_f_s >= 10'sd255) begin
      result_s = {sign_r, 8'hFF, 23'd0};
    end else if (exp_f_s <= 10'sd0) begin
      result_s = {sign_r, 31'd0};
    end else begin
      result_s = {sign_r, exp_f_s[7:0], mant_f_s};
    end
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // next-state decode
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE:    if (start) state_nx_s = UNPACK; else state_nx_s = IDLE;
      UNPACK:  if (special_s) state_nx_s = FINISH; else state_nx_s = MUL;
      MUL:     if (count_r == LAST_CNT) state_nx_s = FINISH; else state_nx_s = MUL;
      FINISH:  state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // datapath and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_r       <= 32'd0;
      b_r       <= 32'd0;
      mb_r      <= 24'd0;
      acc_r     <= 48'd0;
      count_r   <= 5'd0;
      exp_sum_r <= 10'sd0;
      sign_r    <= 1'b0;
      special_r <= 1'b0;
      preset_r  <= 32'd0;
      o_z       <= 32'd0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      o_busy <= (state_nx_s != IDLE);
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r <= i_a;
            b_r <= i_b;
          end
        end
        UNPACK: begin
          sign_r    <= z_sign_s;
          exp_sum_r <= exp_sum_s;
          special_r <= special_s;
          preset_r  <= preset_s;
          acc_r     <= 48'd0;
          count_r   <= 5'd0;
          mb_r      <= {1'b1, b_r[22:0]};
        end
        MUL: begin
          acc_r   <= acc_nx_s;
          mb_r    <= mb_r << BITS_PER_CYCLE;
          count_r <= count_r + 5'd1;
        end
        FINISH: begin
          o_z    <= special_r ? preset_r : result_s;
          o_done <= 1'b1;
        end
        default: begin
          o_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_sp.sv
// -----------------------------------------------------------------------------
// tb_mul_sp : self-checking bench for mul_sp
// Directed cases from the datasheet examples plus randomized operands checked
// against a plain-arithmetic IEEE single-precision multiply model.
// -----------------------------------------------------------------------------
module tb_mul_sp;

  localparam int BPC = 4;
  localparam int K   = 24 / BPC;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] i_a, i_b;
  logic [31:0] o_z;
  logic        o_busy, o_done;

  int total = 0;
  int bad   = 0;

  mul_sp #(.BITS_PER_CYCLE(BPC)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .i_a   (i_a),
    .i_b   (i_b),
    .o_z   (o_z),
    .o_busy(o_busy),
    .o_done(o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_special(input logic [31:0] a, input logic [31:0] b);
    return (a[30:23] == 8'd0) || (a[30:23] == 8'hFF) ||
           (b[30:23] == 8'd0) || (b[30:23] == 8'hFF);
  endfunction

  // reference: exact product, then round the real value to 24 significant bits
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic s;
    int ea, eb, e, sh;
    bit an, bn, ai, bi, az, bz;
    longint unsigned ma, mb, p, mant, rem, half;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    an = (ea == 255) && (a[22:0] != 23'd0);
    bn = (eb == 255) && (b[22:0] != 23'd0);
    ai = (ea == 255) && (a[22:0] == 23'd0);
    bi = (eb == 255) && (b[22:0] == 23'd0);
    az = (ea == 0);
    bz = (eb == 0);
    if (an || bn || (ai && bz) || (bi && az)) return 32'h7FC0_0000;
    if (ai || bi) return {s, 8'hFF, 23'd0};
    if (az || bz) return {s, 31'd0};
    ma = 64'h80_0000 + 64'(a[22:0]);
    mb = 64'h80_0000 + 64'(b[22:0]);
    p  = ma * mb;
    e  = ea + eb - 127;
    if (p >= 64'h8000_0000_0000) begin
      sh = 24;
      e  = e + 1;
    end else begin
      sh = 23;
    end
    mant = p >> sh;
    rem  = p - (mant << sh);
    half = 64'd1 << (sh - 1);
`ifdef ROUND_NEAREST_EN
    if ((rem > half) || ((rem == half) && (mant % 64'd2 == 64'd1))) mant = mant + 64'd1;
`endif
    if (mant == 64'h100_0000) begin
      mant = 64'h80_0000;
      e    = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0)   return {s, 31'd0};
    return {s, 8'(e), 23'(mant)};
  endfunction

  // one operation: start at a falling edge, wait (bounded) for o_done, check,
  // then optionally watch 'tail' idle cycles for spurious o_done / o_z change
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_z, input int exp_lat,
                        input bit inject, input int tail, input string tag);
    int n;
    bit got, extra;
    i_a   = a;
    i_b   = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    i_a   = $urandom;
    i_b   = $urandom;
    n     = 0;
    got   = 1'b0;
    while (n < 60) begin
      if (o_done) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      n++;
      if (n == 1) chk({tag, "_busy"}, 32'(o_busy), 32'd1);
      if (inject) start = (n == 2);
    end
    start = 1'b0;
    chk({tag, "_done"}, 32'(got), 32'd1);
    chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
    chk({tag, "_z"}, o_z, exp_z);
    chk({tag, "_idle"}, 32'(o_busy), 32'd0);
    extra = 1'b0;
    for (int i = 0; i < tail; i++) begin
      @(negedge clk);
      if (o_done || (o_z !== exp_z)) extra = 1'b1;
    end
    if (tail > 0) chk({tag, "_tail"}, 32'(extra), 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    bit seen;
    reset = 1'b1;
    start = 1'b0;
    i_a   = 32'd0;
    i_b   = 32'd0;
    #12;
    chk("rst_z", o_z, 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // basic product, then back-to-back operations
    run_op(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, K + 2, 1'b0, 0, "two_x_three");
`ifdef ROUND_NEAREST_EN
    run_op(32'h3FC0_0001, 32'h3FC0_0001, 32'h4010_0002, K + 2, 1'b0, 0, "round");
    run_op(32'h3FC0_0000, 32'h3F80_0001, 32'h3FC0_0002, K + 2, 1'b0, 2, "tie_odd");
`else
    run_op(32'h3FC0_0001, 32'h3FC0_0001, 32'h4010_0001, K + 2, 1'b0, 0, "round");
    run_op(32'h3FC0_0000, 32'h3F80_0001, 32'h3FC0_0001, K + 2, 1'b0, 2, "tie_odd");
`endif
    run_op(32'h3FC0_0000, 32'h3F80_0003, 32'h3FC0_0004, K + 2, 1'b0, 2, "tie_even");

    // specials and range limits
    run_op(32'hFF80_0000, 32'h0000_0000, 32'h7FC0_0000, 2, 1'b0, 0, "inf_x_zero");
    run_op(32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000, 2, 1'b0, 2, "inf_x_neg");
    run_op(32'h7FC1_2345, 32'h3F80_0000, 32'h7FC0_0000, 2, 1'b0, 2, "nan_in");
    run_op(32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 2, 1'b0, 2, "neg_zero");
    run_op(32'h0040_0000, 32'h4000_0000, 32'h0000_0000, 2, 1'b0, 2, "subnormal");
    run_op(32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, K + 2, 1'b0, 2, "overflow");
    run_op(32'h0080_0000, 32'h0080_0000, 32'h0000_0000, K + 2, 1'b0, 2, "underflow");

    // reset in the middle of MUL aborts without o_done
    i_a   = 32'h4000_0000;
    i_b   = 32'h4040_0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy_before", 32'(o_busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(o_busy), 32'd0);
    chk("mid_rst_z", o_z, 32'd0);
    chk("mid_rst_done", 32'(o_done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen  = 1'b0;
    repeat (K + 4) begin
      @(negedge clk);
      if (o_done || o_busy) seen = 1'b1;
    end
    chk("mid_rst_quiet", 32'(seen), 32'd0);
    run_op(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, K + 2, 1'b0, 2, "after_rst");

    // start while busy is ignored
    run_op(32'h4080_0000, 32'hC0A0_0000, 32'hC1A0_0000, K + 2, 1'b1, K + 4, "busy_start");

    // randomized operands against the model
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) begin
        ra = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
        rb = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
      end else begin
        ra = $urandom;
        rb = $urandom;
      end
      run_op(ra, rb, ref_mul(ra, rb), is_special(ra, rb) ? 2 : K + 2, 1'b0,
             (i % 3 == 0) ? 1 : 0, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
